// File: rtl/cpu_intctl_if.sv
// Pipeline-side bus of the interrupt controller: CSR access port plus the
// interrupt request / acknowledge / return handshake.
interface cpu_intctl_if;
    logic        csr_we;
    logic [2:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        int_req;
    logic [31:0] int_vector;
    logic [7:0]  int_cause;
    logic        int_ack;
    logic        rti;

    modport master (
        output csr_we, csr_addr, csr_wdata, int_ack, rti,
        input  csr_rdata, int_req, int_vector, int_cause
    );

    modport slave (
        input  csr_we, csr_addr, csr_wdata, int_ack, rti,
        output csr_rdata, int_req, int_vector, int_cause
    );
endinterface

// File: rtl/cpu_intctl.sv
// Vectored interrupt controller: source 0 is an internal countdown timer, sources 1..NUM_IRQ
// are external edge/level requests, with masking, strict-priority preemption and a req/ack handshake.
module cpu_intctl #(
    parameter int          NUM_IRQ     = 7,
    parameter int          TIMER_WIDTH = 32,
    parameter logic [31:0] VEC_BASE    = 32'hffff0008
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_enable,
    cpu_intctl_if.slave        bus
);
    localparam int N = NUM_IRQ + 1;
    localparam logic [N-1:0]           ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [TIMER_WIDTH-1:0] TMR_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] A_IPEND   = 3'd0;
    localparam logic [2:0] A_IMASK   = 3'd1;
    localparam logic [2:0] A_IEDGE   = 3'd2;
    localparam logic [2:0] A_TIMER   = 3'd3;
    localparam logic [2:0] A_TRELOAD = 3'd4;
    localparam logic [2:0] A_TCTRL   = 3'd5;
    localparam logic [2:0] A_IACTIVE = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

    // Index of the lowest set bit; N when the vector is empty.
    function automatic logic [5:0] lowest_set(input logic [N-1:0] v);
        logic [5:0] idx;
        idx = 6'(N);
        for (int i = N - 1; i >= 0; i--) begin
            idx = v[i] ? 6'(i) : idx;
        end
        return idx;
    endfunction

    state_t                 state_r, state_next_s;
    logic [N-1:0]           ipend_r, imask_r, iedge_r, iactive_r;
    logic [NUM_IRQ-1:0]     irq_prev_r;
    logic [TIMER_WIDTH-1:0] timer_r, treload_r;
    logic [1:0]             tctrl_r;
    logic [4:0]             win_r, win_next_s;
    logic                   int_req_r, req_next_s;
    logic [31:0]            int_vector_r, vec_next_s;
    logic [7:0]             int_cause_r, cause_next_s;
    logic [N-1:0]           elig_s, win_oh_s, rise_s, level_s, edge_mode_s;
    logic [N-1:0]           clr_s, ack_set_s, rti_clr_s, pend_next_s;
    logic [5:0]             win_idx_s, act_lo_s;
    logic                   wr_s, win_valid_s, held_elig_s, ack_fire_s, tmr_zero_s;
    logic [31:0]            rdata_s;

    assign wr_s        = bus.csr_we && !stall;
    assign elig_s      = ipend_r & imask_r;
    assign win_idx_s   = lowest_set(elig_s);
    assign act_lo_s    = lowest_set(iactive_r);
    assign win_valid_s = int_enable && (win_idx_s < act_lo_s);
    assign win_oh_s    = ONE_N << win_r;
    assign held_elig_s = |(elig_s & win_oh_s);
    assign ack_fire_s  = (state_r == REQ) && bus.int_ack && !stall && held_elig_s;
    assign tmr_zero_s  = tctrl_r[0] && (timer_r == '0);

    // Pending/active next-state: a new edge outranks any same-cycle clear.
    always_comb begin
        rise_s      = {irq_in & ~irq_prev_r, tmr_zero_s};
        level_s     = {irq_in, 1'b0};
        edge_mode_s = iedge_r | ONE_N;
        ack_set_s   = ack_fire_s ? win_oh_s : '0;
        clr_s       = ack_set_s | ((wr_s && bus.csr_addr == A_IPEND) ? bus.csr_wdata[N-1:0] : '0);
        pend_next_s = (edge_mode_s & (rise_s | (ipend_r & ~clr_s))) | (~edge_mode_s & level_s);
        rti_clr_s   = (bus.rti && !stall) ? (iactive_r & (~iactive_r + ONE_N)) : '0;
    end

    // Interrupt CSRs and edge samples; stall freezes them except the timer's pending bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ipend_r    <= '0;
            imask_r    <= '0;
            iedge_r    <= '0;
            iactive_r  <= '0;
            irq_prev_r <= '0;
        end else if (stall) begin
            ipend_r <= ipend_r | {{NUM_IRQ{1'b0}}, tmr_zero_s};
        end else begin
            ipend_r    <= pend_next_s;
            irq_prev_r <= irq_in;
            iactive_r  <= (iactive_r & ~rti_clr_s) | ack_set_s;
            if (wr_s && bus.csr_addr == A_IMASK) imask_r <= bus.csr_wdata[N-1:0];
            if (wr_s && bus.csr_addr == A_IEDGE) iedge_r <= bus.csr_wdata[N-1:0];
        end
    end

    // Timer runs regardless of stall; a TIMER write beats decrement and reload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_r   <= '1;
            treload_r <= '1;
            tctrl_r   <= 2'b00;
        end else begin
            if (bus.csr_we && bus.csr_addr == A_TIMER) timer_r <= bus.csr_wdata[TIMER_WIDTH-1:0];
            else if (tmr_zero_s) timer_r <= tctrl_r[1] ? treload_r : timer_r;
            else if (tctrl_r[0]) timer_r <= timer_r - TMR_ONE;
            if (wr_s && bus.csr_addr == A_TRELOAD) treload_r <= bus.csr_wdata[TIMER_WIDTH-1:0];
            if (wr_s && bus.csr_addr == A_TCTRL) tctrl_r <= bus.csr_wdata[1:0];
            else if (tmr_zero_s && !tctrl_r[1]) tctrl_r <= {tctrl_r[1], 1'b0};
        end
    end

    // FSM state and registered request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            int_req_r    <= 1'b0;
            int_vector_r <= VEC_BASE;
            int_cause_r  <= 8'h00;
            win_r        <= 5'd0;
        end else begin
            state_r      <= state_next_s;
            int_req_r    <= req_next_s;
            int_vector_r <= vec_next_s;
            int_cause_r  <= cause_next_s;
            win_r        <= win_next_s;
        end
    end

    // FSM next state; a request that loses eligibility is withdrawn rather than acked.
    always_comb begin
        state_next_s = state_r;
        if (stall) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                IDLE:    state_next_s = win_valid_s ? REQ : IDLE;
                REQ:     state_next_s = !held_elig_s ? IDLE : (bus.int_ack ? HOLD : REQ);
                HOLD:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM outputs: vector/cause latched once on entry to REQ and held stable.
    always_comb begin
        req_next_s   = (state_next_s == REQ);
        win_next_s   = win_r;
        vec_next_s   = int_vector_r;
        cause_next_s = int_cause_r;
        if (state_r == IDLE && state_next_s == REQ) begin
            win_next_s   = win_idx_s[4:0];
            vec_next_s   = VEC_BASE + {24'd0, win_idx_s, 2'b00};
            cause_next_s = 8'h80 | {2'b00, win_idx_s};
        end else begin
            win_next_s   = win_r;
        end
    end

    // CSR read mux.
    always_comb begin
        case (bus.csr_addr)
            A_IPEND:   rdata_s = 32'(ipend_r);
            A_IMASK:   rdata_s = 32'(imask_r);
            A_IEDGE:   rdata_s = 32'(iedge_r);
            A_TIMER:   rdata_s = 32'(timer_r);
            A_TRELOAD: rdata_s = 32'(treload_r);
            A_TCTRL:   rdata_s = {30'd0, tctrl_r};
            A_IACTIVE: rdata_s = 32'(iactive_r);
            default:   rdata_s = 32'd0;
        endcase
    end

    assign bus.csr_rdata  = rdata_s;
    assign bus.int_req    = int_req_r;
    assign bus.int_vector = int_vector_r;
    assign bus.int_cause  = int_cause_r;
endmodule

// File: tb/tb_cpu_intctl.sv
// Directed bench for cpu_intctl: hand-computed expectations for reset, priority,
// preemption, level withdrawal, W1C race, timer and asynchronous reset.
module tb_cpu_intctl;
    logic       clock = 1'b0;
    logic       reset;
    logic       stall;
    logic [6:0] irq_in;
    logic       int_enable;
    int         total = 0;
    int         bad   = 0;

    cpu_intctl_if bus ();

    cpu_intctl dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .irq_in     (irq_in),
        .int_enable (int_enable),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_csr(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        check(tag, bus.csr_rdata, exp);
    endtask

    task automatic check_req(input string tag, input logic exp);
        check(tag, {31'd0, bus.int_req}, {31'd0, exp});
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        tick();
        bus.csr_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic pulse_rti();
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; irq_in = 7'd0; int_enable = 1'b0;
        bus.csr_we = 1'b0; bus.csr_addr = 3'd0; bus.csr_wdata = 32'd0;
        bus.int_ack = 1'b0; bus.rti = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_req("rst_req", 1'b0);
        check("rst_vec", bus.int_vector, 32'hffff0008);
        check("rst_cause", {24'd0, bus.int_cause}, 32'h0);
        check_csr("rst_ipend", 3'd0, 32'h0);
        check_csr("rst_timer", 3'd3, 32'hffffffff);
        check_csr("rst_treload", 3'd4, 32'hffffffff);
        check_csr("rst_tctrl", 3'd5, 32'h0);
        check_csr("rst_unmapped", 3'd7, 32'h0);
        reset = 1'b0;
        tick();

        // Single edge source 1: two-cycle latency, then ack.
        int_enable = 1'b1;
        csr_wr(3'd2, 32'h2);
        csr_wr(3'd1, 32'h2);
        csr_wr(3'd7, 32'h5);
        check_csr("unmapped_wr", 3'd7, 32'h0);
        irq_in = 7'b0000001;
        tick();
        check_csr("e1_ipend", 3'd0, 32'h2);
        check_req("e1_req_n1", 1'b0);
        tick();
        check_req("e1_req", 1'b1);
        check("e1_vec", bus.int_vector, 32'hffff000c);
        check("e1_cause", {24'd0, bus.int_cause}, 32'h81);
        pulse_ack();
        check_req("e1_hold", 1'b0);
        check_csr("e1_ipend_clr", 3'd0, 32'h0);
        check_csr("e1_iactive", 3'd6, 32'h2);
        tick();
        check_req("e1_idle", 1'b0);
        pulse_rti();
        check_csr("e1_rti", 3'd6, 32'h0);
        irq_in = 7'd0;

        // Priority and preemption among sources 2..5.
        csr_wr(3'd2, 32'h3e);
        csr_wr(3'd1, 32'h3e);
        irq_in = 7'b0010100;
        tick();
        check_csr("pp_ipend", 3'd0, 32'h28);
        tick();
        check_req("pp_req3", 1'b1);
        check("pp_cause3", {24'd0, bus.int_cause}, 32'h83);
        check("pp_vec3", bus.int_vector, 32'hffff0014);
        pulse_ack();
        check_csr("pp_act3", 3'd6, 32'h08);
        check_csr("pp_ipend5", 3'd0, 32'h20);
        irq_in = 7'b0010110;
        tick();
        tick();
        check_req("pp_req2", 1'b1);
        check("pp_cause2", {24'd0, bus.int_cause}, 32'h82);
        pulse_ack();
        check_csr("pp_act23", 3'd6, 32'h0c);
        irq_in = 7'b0011110;
        tick();
        check_csr("pp_ipend45", 3'd0, 32'h30);
        tick();
        check_req("pp_blk4_a", 1'b0);
        pulse_rti();
        check_csr("pp_rti1", 3'd6, 32'h08);
        check_req("pp_blk4_b", 1'b0);
        tick();
        check_req("pp_blk4_c", 1'b0);
        pulse_rti();
        check_csr("pp_rti2", 3'd6, 32'h0);
        tick();
        check_req("pp_req4", 1'b1);
        check("pp_cause4", {24'd0, bus.int_cause}, 32'h84);
        pulse_ack();
        check_csr("pp_act4", 3'd6, 32'h10);
        irq_in = 7'd0;
        csr_wr(3'd1, 32'h0);
        csr_wr(3'd0, 32'hff);
        pulse_rti();
        check_csr("pp_clean_act", 3'd6, 32'h0);
        check_csr("pp_clean_pend", 3'd0, 32'h0);

        // Level source withdrawn before ack.
        csr_wr(3'd2, 32'h0);
        csr_wr(3'd1, 32'h2);
        irq_in = 7'b0000001;
        tick();
        check_csr("lv_ipend", 3'd0, 32'h2);
        tick();
        check_req("lv_req", 1'b1);
        irq_in = 7'd0;
        tick();
        tick();
        check_req("lv_drop", 1'b0);
        check_csr("lv_ipend0", 3'd0, 32'h0);
        check_csr("lv_iactive", 3'd6, 32'h0);

        // W1C racing a new edge keeps the bit; plain W1C clears it.
        csr_wr(3'd1, 32'h0);
        csr_wr(3'd2, 32'h2);
        irq_in = 7'b0000001;
        tick();
        irq_in = 7'd0;
        tick();
        check_csr("w1c_pre", 3'd0, 32'h2);
        irq_in = 7'b0000001;
        csr_wr(3'd0, 32'h2);
        check_csr("w1c_race", 3'd0, 32'h2);
        csr_wr(3'd0, 32'h2);
        check_csr("w1c_plain", 3'd0, 32'h0);
        irq_in = 7'd0;

        // Timer auto-reload, counting under stall, one-shot.
        int_enable = 1'b0;
        csr_wr(3'd1, 32'h1);
        csr_wr(3'd4, 32'h3);
        csr_wr(3'd3, 32'h3);
        csr_wr(3'd5, 32'h3);
        check_csr("tm_3", 3'd3, 32'h3);
        tick();
        check_csr("tm_2", 3'd3, 32'h2);
        tick();
        check_csr("tm_1", 3'd3, 32'h1);
        tick();
        check_csr("tm_0", 3'd3, 32'h0);
        check_csr("tm_nopend", 3'd0, 32'h0);
        tick();
        check_csr("tm_reload", 3'd3, 32'h3);
        check_csr("tm_pend", 3'd0, 32'h1);
        csr_wr(3'd0, 32'h1);
        check_csr("tm_w1c", 3'd0, 32'h0);
        stall = 1'b1;
        tick();
        check_csr("st_1", 3'd3, 32'h1);
        tick();
        check_csr("st_0", 3'd3, 32'h0);
        tick();
        check_csr("st_reload", 3'd3, 32'h3);
        check_csr("st_pend", 3'd0, 32'h1);
        csr_wr(3'd1, 32'h7f);
        check_csr("st_imask_frozen", 3'd1, 32'h1);
        csr_wr(3'd3, 32'h10);
        check_csr("st_timer_wr", 3'd3, 32'h10);
        stall = 1'b0;
        csr_wr(3'd5, 32'h0);
        check_csr("tm_tctrl_off", 3'd5, 32'h0);
        tick();
        check_csr("tm_frozen", 3'd3, 32'h0f);
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd3, 32'h1);
        csr_wr(3'd5, 32'h1);
        tick();
        check_csr("os_0", 3'd3, 32'h0);
        tick();
        check_csr("os_tctrl", 3'd5, 32'h0);
        check_csr("os_timer", 3'd3, 32'h0);
        check_csr("os_pend", 3'd0, 32'h1);

        // Asynchronous reset while a request is outstanding.
        int_enable = 1'b1;
        csr_wr(3'd2, 32'h2);
        csr_wr(3'd1, 32'h2);
        irq_in = 7'b0000001;
        tick();
        tick();
        check_req("ar_req", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_req("ar_req_async", 1'b0);
        check("ar_vec", bus.int_vector, 32'hffff0008);
        check_csr("ar_ipend", 3'd0, 32'h0);
        check_csr("ar_imask", 3'd1, 32'h0);
        check_csr("ar_iedge", 3'd2, 32'h0);
        check_csr("ar_timer", 3'd3, 32'hffffffff);
        check_csr("ar_treload", 3'd4, 32'hffffffff);
        check_csr("ar_tctrl", 3'd5, 32'h0);
        check_csr("ar_iactive", 3'd6, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check_req("ar_post1", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_intctl.md
CPU_INTCTL -- requirements
Module: cpu_intctl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 7, external interrupt source count (1..31); total sources N = NUM_IRQ+1, and source 0 is the internal timer.
REQ-002 SHALL have parameter TIMER_WIDTH, default 32, timer counter width (8..32).
REQ-003 SHALL have parameter VEC_BASE, default 32'hffff0008, vector of source 0; vector(i) = VEC_BASE + 4*i.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports: clock  in  1  system clock.
REQ-005 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port: stall  in  1  pipeline stall; freezes all state except the timer.
REQ-007 SHALL have port: irq_in  in  NUM_IRQ  external requests, synchronous to clock; bit k is source k+1.
REQ-008 SHALL have port: int_enable  in  1  global enable (status interrupt flag).
REQ-009 SHALL have port: csr_we  in  1  CSR write strobe.
REQ-010 SHALL have port: csr_addr  in  3  CSR select.
REQ-011 SHALL have port: csr_wdata  in  32  CSR write data.
REQ-012 SHALL have port: csr_rdata  out  32  CSR read data, combinational, zero-extended.
REQ-013 SHALL have port: int_req  out  1  interrupt request to the pipeline.
REQ-014 SHALL have port: int_vector  out  32  handler address.
REQ-015 SHALL have port: int_cause  out  8  8'h80 | source index.
REQ-016 SHALL have port: int_ack  in  1  pipeline accepts the request.
REQ-017 SHALL have port: rti  in  1  return-from-interrupt retired.

Function
REQ-018 CSR map SHALL be 0 IPEND (write-1-clear, edge bits only), 1 IMASK, 2 IEDGE (1 = edge mode), 3 TIMER, 4 TRELOAD, 5 TCTRL (bit0 enable, bit1 auto-reload), 6 IACTIVE (read-only); unmapped addresses read 0 and writes are ignored.
REQ-019 Edge source SHALL set IPEND on rising edge vs previous-cycle sample; level source IPEND SHALL mirror its input; timer is edge mode regardless of IEDGE[0].
REQ-020 Eligible set SHALL be IPEND & IMASK; winner SHALL be the lowest eligible index, requested only if below the lowest set IACTIVE bit (strict preemption) and int_enable=1.
REQ-021 FSM SHALL have states IDLE, REQ and HOLD; IDLE->REQ when a winner exists, latching int_vector/int_cause for that winner; REQ holds int_req=1 with stable vector/cause.
REQ-022 In REQ, int_ack & !stall SHALL set IACTIVE[winner], clear the winner's edge IPEND, and go to HOLD; if the winner becomes ineligible before ack, SHALL drop int_req and return to IDLE next cycle.
REQ-023 HOLD SHALL last exactly one cycle with int_req=0, then go to IDLE.
REQ-024 Latency: edge at cycle N -> IPEND at N+1 -> int_req at N+2.
REQ-025 rti & !stall SHALL clear the lowest set IACTIVE bit; rti with IACTIVE=0 SHALL have no effect.
REQ-026 A same-cycle edge set and ack/W1C clear on one bit SHALL leave the bit set.
REQ-027 Timer SHALL decrement every cycle while enabled, ignoring stall; at 0 it SHALL set IPEND[0], then reload TRELOAD if auto-reload, else clear the enable.
REQ-028 A CSR write to TIMER SHALL take priority over decrement and reload; other CSR writes SHALL take effect only when !stall.
REQ-029 TIMER values SHALL be zero-extended from TIMER_WIDTH bits, and writes SHALL be truncated to TIMER_WIDTH bits.

Reset
REQ-030 Reset SHALL force: FSM=IDLE, int_req=0, int_vector=VEC_BASE, int_cause=0, IPEND/IMASK/IEDGE/IACTIVE=0, TCTRL=0, TIMER and TRELOAD all ones, edge samples 0.
REQ-031 Reset asserted mid-request SHALL drop int_req asynchronously, and no interrupt SHALL issue in the first cycle after release.

Verification
REQ-032 IEDGE=2, IMASK=2, int_enable=1, irq_in[0] rises at cycle 10 -> int_req=1 at cycle 12, int_vector=ffff000c, int_cause=81; ack -> IPEND[1]=0, IACTIVE=2.
REQ-033 Sources 3 and 5 pending and masked in, IACTIVE=0 -> cause 83; ack, then source 2 rises -> preempts with cause 82; a further source-4 request is blocked until two rti pulses.
REQ-034 TRELOAD=3, TCTRL=3, IMASK=1 -> timer sequence 3,2,1,0,3 and IPEND[0] set every 4 cycles; with stall=1 throughout, the timer still counts.
REQ-035 Level source 1 asserted then deasserted before ack -> int_req drops, FSM returns to IDLE, IACTIVE unchanged.
REQ-036 W1C of IPEND on the same cycle as a new edge on that source -> bit remains 1.
REQ-037 Reset pulse while int_req=1 -> int_req=0 immediately, and all CSRs read their REQ-030 values.
